// File: rtl/dds_sweep_pkg.sv
// dds_sweep_pkg
//   Shared definitions for the DDS tuning-word sweep sequencer.
//   - FW_DEF / DWW_DEF : default tuning-word and dwell-counter widths
//   - MODE_*           : sweep mode encodings (3 decodes as single)
//   - state_t          : sequencer state encoding, also driven out on state_dbg
package dds_sweep_pkg;

    localparam int FW_DEF  = 32;
    localparam int DWW_DEF = 24;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_REPEAT = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;

    // LOAD and STEP are the first cycle a freshly loaded or stepped word is
    // visible on fre_k. DWELL covers the remaining hold cycles.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DWELL = 3'd2,
        ST_STEP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer
//   Loadable down-counter that measures how long each tuning word is held.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//     load       : load load_val this cycle (has priority over counting)
//     load_val   : reload value, i.e. hold cycles minus one
//     zero       : count has reached zero (the hold expires this cycle)
//   The count stops at zero rather than wrapping.
module dds_dwell_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
//   Steps the DDS tuning word from f_start to f_stop in f_step increments,
//   holding each word for max(dwell,1) cycles. Modes: single, repeat, triangle.
//   Ports:
//     clk, rst_n       : clk_125m domain clock, asynchronous active-low reset
//     start, stop      : 1-cycle command pulses (stop has priority)
//     mode, f_start, f_stop, f_step, dwell : sweep config, latched on accepted start
//     fre_k            : tuning word to the phase accumulator
//     fre_k_vld        : pulses on each cycle fre_k takes a new value
//     acc_clr          : pulses with fre_k_vld when a sweep (re)starts at f_start
//     busy, done       : sweep in progress / 1-cycle end of single sweep
//     dir_down         : current sweep direction (1 = decreasing)
//     state_dbg        : current sequencer state (state_t encoding)
//   fre_k_vld carries no handshake: the accumulator cannot stall the sweep,
//   it simply takes fre_k on every cycle fre_k_vld is high.
//   All outputs are registered, so an accepted start at cycle n shows the
//   first word with fre_k_vld/acc_clr at cycle n+1.
module dds_sweep_ctrl
    import dds_sweep_pkg::*;
#(
    parameter int FW  = FW_DEF,
    parameter int DWW = DWW_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           stop,
    input  logic [1:0]     mode,
    input  logic [FW-1:0]  f_start,
    input  logic [FW-1:0]  f_stop,
    input  logic [FW-1:0]  f_step,
    input  logic [DWW-1:0] dwell,
    output logic [FW-1:0]  fre_k,
    output logic           fre_k_vld,
    output logic           acc_clr,
    output logic           busy,
    output logic           done,
    output logic           dir_down,
    output logic [2:0]     state_dbg
);

    state_t         state, state_nxt;

    // Shadow config: fixed for the whole sweep; triangle swaps start/end.
    logic [1:0]     cur_mode, cur_mode_nxt;
    logic [FW-1:0]  cur_start, cur_start_nxt;
    logic [FW-1:0]  cur_end, cur_end_nxt;
    logic [FW-1:0]  cur_step, cur_step_nxt;
    logic [DWW-1:0] cur_dwell, cur_dwell_nxt;

    logic [FW-1:0]  fre_k_nxt;
    logic           vld_nxt, clr_nxt, busy_nxt, done_nxt, dir_nxt;

    logic           tmr_load, tmr_zero;
    logic [DWW-1:0] tmr_val, cfg_reload, in_reload;

    logic [FW:0]    wide_up, wide_dn;
    logic [FW-1:0]  step_lim, step_word;
    logic           at_end, turn, step_down;

    dds_dwell_timer #(.W(DWW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // dwell of 0 holds for one cycle, same as dwell of 1.
    assign cfg_reload = (cur_dwell == '0) ? '0 : cur_dwell - DWW'(1);
    assign in_reload  = (dwell == '0) ? '0 : dwell - DWW'(1);

    // Step unit. At a triangle turn-around the next word already moves in the
    // new direction towards the old start, so direction and limit are taken
    // pre-swapped here. The extra MSB catches carry/borrow past the word range.
    always_comb begin
        wide_up   = {1'b0, fre_k} + {1'b0, cur_step};
        wide_dn   = {1'b0, fre_k} - {1'b0, cur_step};
        at_end    = (fre_k == cur_end) || (cur_step == '0);
        turn      = at_end && (cur_mode == MODE_TRI);
        step_down = turn ? ~dir_down : dir_down;
        step_lim  = turn ? cur_start : cur_end;
        if (step_down) begin
            step_word = (wide_dn[FW] || (wide_dn[FW-1:0] < step_lim)) ? step_lim : wide_dn[FW-1:0];
        end else begin
            step_word = (wide_up[FW] || (wide_up[FW-1:0] > step_lim)) ? step_lim : wide_up[FW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cur_mode_nxt  = cur_mode;
        cur_start_nxt = cur_start;
        cur_end_nxt   = cur_end;
        cur_step_nxt  = cur_step;
        cur_dwell_nxt = cur_dwell;
        fre_k_nxt     = fre_k;
        vld_nxt       = 1'b0;
        clr_nxt       = 1'b0;
        done_nxt      = 1'b0;
        busy_nxt      = busy;
        dir_nxt       = dir_down;
        tmr_load      = 1'b0;
        tmr_val       = cfg_reload;

        if (stop) begin
            // Abort keeps the last word on fre_k; in IDLE this changes nothing.
            if (state != ST_IDLE) begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_mode_nxt  = mode;
                        cur_start_nxt = f_start;
                        cur_end_nxt   = f_stop;
                        cur_step_nxt  = f_step;
                        cur_dwell_nxt = dwell;
                        dir_nxt       = (f_stop < f_start);
                        fre_k_nxt     = f_start;
                        vld_nxt       = 1'b1;
                        clr_nxt       = 1'b1;
                        busy_nxt      = 1'b1;
                        tmr_load      = 1'b1;
                        tmr_val       = in_reload;
                        state_nxt     = ST_LOAD;
                    end
                end
                ST_LOAD, ST_DWELL, ST_STEP: begin
                    if (!tmr_zero) begin
                        state_nxt = ST_DWELL;
                    end else if (at_end && (cur_mode == MODE_REPEAT)) begin
                        fre_k_nxt = cur_start;
                        vld_nxt   = 1'b1;
                        clr_nxt   = 1'b1;
                        tmr_load  = 1'b1;
                        state_nxt = ST_LOAD;
                    end else if (at_end && (cur_mode != MODE_TRI)) begin
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        state_nxt = ST_DONE;
                    end else begin
                        if (turn) begin
                            cur_start_nxt = cur_end;
                            cur_end_nxt   = cur_start;
                            dir_nxt       = ~dir_down;
                        end
                        fre_k_nxt = step_word;
                        vld_nxt   = 1'b1;
                        tmr_load  = 1'b1;
                        state_nxt = ST_STEP;
                    end
                end
                ST_DONE: state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_mode  <= MODE_SINGLE;
            cur_start <= '0;
            cur_end   <= '0;
            cur_step  <= '0;
            cur_dwell <= '0;
            fre_k     <= '0;
            fre_k_vld <= 1'b0;
            acc_clr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dir_down  <= 1'b0;
        end else begin
            cur_mode  <= cur_mode_nxt;
            cur_start <= cur_start_nxt;
            cur_end   <= cur_end_nxt;
            cur_step  <= cur_step_nxt;
            cur_dwell <= cur_dwell_nxt;
            fre_k     <= fre_k_nxt;
            fre_k_vld <= vld_nxt;
            acc_clr   <= clr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            dir_down  <= dir_nxt;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl
//   Self-checking bench for dds_sweep_ctrl. A reference model turns each
//   sweep command into a list of timed word updates and done pulses; a
//   monitor pops and compares them whenever the DUT pulses fre_k_vld or done.
module tb_dds_sweep_ctrl;
    import dds_sweep_pkg::*;

    localparam int FW  = 32;
    localparam int DWW = 24;
    localparam int EW  = 16 + 1 + 1 + 32;  // {cycle, acc_clr, dir_down, fre_k}
    localparam int DW  = 16 + 32;          // {cycle, fre_k}

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start, stop;
    logic [1:0]     mode;
    logic [FW-1:0]  f_start, f_stop, f_step;
    logic [DWW-1:0] dwell;
    logic [FW-1:0]  fre_k;
    logic           fre_k_vld, acc_clr, busy, done, dir_down;
    logic [2:0]     state_dbg;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [EW-1:0] exp_q[$];
    logic [DW-1:0] done_q[$];
    logic [EW-1:0] e_ev, a_ev;
    logic [DW-1:0] e_dn, a_dn;

    dds_sweep_ctrl #(.FW(FW), .DWW(DWW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .dwell     (dwell),
        .fre_k     (fre_k),
        .fre_k_vld (fre_k_vld),
        .acc_clr   (acc_clr),
        .busy      (busy),
        .done      (done),
        .dir_down  (dir_down),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    // Walks the sweep with plain integer arithmetic. last == 0: run to done;
    // otherwise only events up to cycle 'last' (stop issued in that cycle).
    task automatic model_sweep(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fe,
                               input logic [31:0] st, input logic [23:0] dw,
                               input int unsigned n, input int unsigned last);
        longint      word, s, e, nx, tmp;
        bit          down, clr;
        int unsigned t, d;
        d    = (dw == 0) ? 1 : int'(dw);
        s    = longint'(fs);
        e    = longint'(fe);
        word = s;
        down = (fe < fs);
        clr  = 1'b1;
        t    = n + 1;
        for (int guard = 0; guard < 5000; guard++) begin
            if (last != 0 && t > last) break;
            exp_q.push_back({t[15:0], clr, down, word[31:0]});
            t = t + d;
            if (word == e || st == 0) begin
                if (m == MODE_REPEAT) begin
                    word = s;
                    clr  = 1'b1;
                    continue;
                end else if (m == MODE_TRI) begin
                    tmp  = s;
                    s    = e;
                    e    = tmp;
                    down = !down;
                end else begin
                    if (last == 0 || t <= last) done_q.push_back({t[15:0], word[31:0]});
                    break;
                end
            end
            nx = down ? word - longint'(st) : word + longint'(st);
            if (down ? (nx < e) : (nx > e)) nx = e;
            word = nx;
            clr  = 1'b0;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (fre_k_vld) begin
                checks++;
                a_ev = {cyc[15:0], acc_clr, dir_down, fre_k};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL vld_unexpected: cyc=%0d fre_k=%0d, required no word update", cyc, fre_k);
                end else begin
                    e_ev = exp_q.pop_front();
                    if (a_ev !== e_ev || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL word_update: got cyc=%0d fre_k=%0d clr=%0b dir=%0b busy=%0b, required cyc=%0d fre_k=%0d clr=%0b dir=%0b busy=1",
                                 cyc[15:0], fre_k, acc_clr, dir_down, busy,
                                 e_ev[49:34], e_ev[31:0], e_ev[33], e_ev[32]);
                    end
                end
            end
            if (done) begin
                checks++;
                a_dn = {cyc[15:0], fre_k};
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: cyc=%0d fre_k=%0d, required no done", cyc, fre_k);
                end else begin
                    e_dn = done_q.pop_front();
                    if (a_dn !== e_dn || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL done_pulse: got cyc=%0d fre_k=%0d busy=%0b, required cyc=%0d fre_k=%0d busy=0",
                                 cyc[15:0], fre_k, busy, e_dn[47:32], e_dn[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver / helper tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fre_k"}, fre_k, 32'd0);
        chk({tag, "_vld"}, 32'(fre_k_vld), 32'd0);
        chk({tag, "_acc_clr"}, 32'(acc_clr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_dir"}, 32'(dir_down), 32'd0);
    endtask

    task automatic scramble_inputs();
        mode    = 2'($urandom_range(0, 3));
        f_start = $urandom;
        f_stop  = $urandom;
        f_step  = $urandom;
        dwell   = 24'($urandom_range(0, 7));
    endtask

    // Start pulse at cycle n; inputs are scrambled afterwards so any use of
    // unlatched config shows up as a wrong word.
    task automatic issue_sweep(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fe,
                               input logic [31:0] st, input logic [23:0] dw,
                               input int unsigned last_rel, output int unsigned n);
        @(negedge clk);
        n = cyc;
        model_sweep(m, fs, fe, st, dw, n, (last_rel == 0) ? 0 : n + last_rel);
        mode    = m;
        f_start = fs;
        f_stop  = fe;
        f_step  = st;
        dwell   = dw;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
    endtask

    task automatic stop_at(input int unsigned s);
        while (cyc < s) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("busy_after_stop", 32'(busy), 32'd0);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d word updates and %0d done pulses still outstanding, required 0",
                     name, exp_q.size(), done_q.size());
            exp_q.delete();
            done_q.delete();
        end
        chk({name, "_idle_busy"}, 32'(busy), 32'd0);
        chk({name, "_idle_state"}, 32'(state_dbg), 32'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int unsigned n;
        logic [1:0]  rm;
        logic [31:0] rfs, rfe, rst;
        logic [23:0] rdw;
        int unsigned rlast;

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode = '0; f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("post_reset");

        // single up sweep
        issue_sweep(2'd0, 32'd1000, 32'd1400, 32'd100, 24'd4, 0, n);
        wait_drain("single_up", 200);

        // clamped final step, up and down
        issue_sweep(2'd0, 32'd1000, 32'd1250, 32'd100, 24'd2, 0, n);
        wait_drain("clamp_up", 200);
        issue_sweep(2'd3, 32'd500, 32'd260, 32'd100, 24'd1, 0, n);
        wait_drain("clamp_down", 200);

        // repeat mode, aborted by stop
        issue_sweep(2'd1, 32'd10, 32'd30, 32'd10, 24'd2, 15, n);
        stop_at(n + 15);
        wait_drain("repeat", 20);

        // triangle mode, aborted by stop
        issue_sweep(2'd2, 32'd10, 32'd30, 32'd10, 24'd1, 12, n);
        stop_at(n + 12);
        wait_drain("triangle", 20);

        // dwell 0 behaves as 1; zero step gives one word
        issue_sweep(2'd0, 32'd5, 32'd8, 32'd1, 24'd0, 0, n);
        wait_drain("dwell0", 100);
        issue_sweep(2'd0, 32'd700, 32'd900, 32'd0, 24'd3, 0, n);
        wait_drain("step0", 100);

        // carry out of the word range clamps to f_stop
        issue_sweep(2'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h200, 24'd2, 0, n);
        wait_drain("carry_clamp", 100);

        // start and stop together: stop wins; stop alone in idle does nothing
        @(negedge clk);
        mode = 2'd0; f_start = 32'd50; f_stop = 32'd80; f_step = 32'd10; dwell = 24'd1;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("start_stop_busy", 32'(busy), 32'd0);

        // start while busy is ignored
        issue_sweep(2'd0, 32'd2000, 32'd2300, 32'd100, 24'd3, 0, n);
        repeat (3) @(negedge clk);
        mode = 2'd1; f_start = 32'd7; f_stop = 32'd9; f_step = 32'd1; dwell = 24'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain("start_busy", 200);

        // asynchronous reset mid-dwell, then a fresh sweep
        issue_sweep(2'd0, 32'd0, 32'd1000, 32'd100, 24'd8, 0, n);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue_sweep(2'd0, 32'd100, 32'd300, 32'd100, 24'd3, 0, n);
        wait_drain("after_reset", 100);

        // randomized sweeps
        for (int i = 0; i < 16; i++) begin
            rm  = 2'($urandom_range(0, 3));
            rfs = $urandom_range(0, 2000);
            rfe = $urandom_range(0, 2000);
            rst = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(40, 400));
            rdw = 24'($urandom_range(0, 4));
            if (rm == MODE_REPEAT || rm == MODE_TRI) begin
                if (rm == MODE_TRI && rst == 0) rst = 32'd100;
                if (rm == MODE_TRI && rfs == rfe) rfe = rfs + 32'd300;
                rlast = $urandom_range(10, 120);
                issue_sweep(rm, rfs, rfe, rst, rdw, rlast, n);
                stop_at(n + rlast);
                wait_drain("rand_cont", 20);
            end else begin
                issue_sweep(rm, rfs, rfe, rst, rdw, 0, n);
                wait_drain("rand_single", 3000);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
